// File: rtl/uart_host_tx_pkg.sv
// uart_host_tx_pkg: FSM encoding, default parameters and line levels shared by uart_host_tx.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_host_tx_pkg;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        START = 3'd1,
        DATA = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP = 3'd4
    } state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO with registered occupancy; ready reflects the count
// from the previous edge, so a push into a full FIFO is refused even when a pop happens that edge.
module uart_tx_fifo
    import uart_host_tx_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             wr_data,
    input  logic                   push,
    output logic                   ready,
    input  logic                   pop,
    output logic [7:0]             rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign ready = count != (AW+1)'(DEPTH);
    assign do_push = push && ready && !rst;
    assign do_pop = pop && count != '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_host_tx.sv
// uart_host_tx: FIFO-buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// UART_TXD is registered from the current state, so the start bit appears one edge after the pop.
module uart_host_tx
    import uart_host_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [7:0]                  TX_DATA,
    input  logic                        TX_VALID,
    output logic                        TX_READY,
    output logic                        UART_TXD,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    state_t state, state_n;
    logic [15:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shreg, fifo_data;
    logic pop, tick, empty, txd_n;
`ifdef UART_TX_PARITY_EN
    logic par;
`endif
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK),
        .rst(RESET),
        .wr_data(TX_DATA),
        .push(TX_VALID),
        .ready(TX_READY),
        .pop(pop),
        .rd_data(fifo_data),
        .count(FIFO_COUNT)
    );
    assign empty = FIFO_COUNT == '0;
    assign tick = baud == LAST;
    assign BUSY = state != IDLE || !empty;
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        pop = 1'b0;
        txd_n = STOP_BIT;
        case (state)
            IDLE: begin
                pop = !empty;
                state_n = empty ? IDLE : START;
            end
            START: begin
                txd_n = START_BIT;
                state_n = tick ? DATA : START;
            end
            DATA: begin
                txd_n = shreg[0];
`ifdef UART_TX_PARITY_EN
                if (tick && bit_idx == 3'd7) state_n = PARITY;
            end
            PARITY: begin
                txd_n = par;
                state_n = tick ? STOP : PARITY;
            end
`else
                if (tick && bit_idx == 3'd7) state_n = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    pop = !empty;
                    state_n = empty ? IDLE : START;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // Baud counter restarts on every bit boundary and is held at zero while idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            baud <= '0;
            bit_idx <= '0;
            shreg <= '0;
            UART_TXD <= STOP_BIT;
        end else begin
            UART_TXD <= txd_n;
            baud <= (state == IDLE || tick) ? '0 : baud + 16'd1;
            if (pop) begin
                shreg <= fifo_data;
                bit_idx <= '0;
            end else if (state == DATA && tick) begin
                shreg <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end
`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RESET) par <= 1'b0;
        else if (pop) par <= ^fifo_data;
    end
`endif
endmodule

// File: tb/tb_uart_host_tx.sv
// tb_uart_host_tx: randomized self-checking bench for uart_host_tx with a UART receiver model.
module tb_uart_host_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic TX_VALID = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic TX_READY, UART_TXD, BUSY;
    logic [3:0] FIFO_COUNT;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;
    logic [7:0] rx_q[$];
    logic [7:0] rx_d;
    bit rx_ok;

    always #5 CLK = ~CLK;

    uart_host_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY),
        .UART_TXD(UART_TXD),
        .BUSY(BUSY),
        .FIFO_COUNT(FIFO_COUNT)
    );

    // Line level of bit i of the frame carrying byte d: start, 8 data LSB first, [even parity], stop.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == NB - 1) return 1'b1;
        return ^d;
    endfunction

    // Receiver model: samples each bit in its middle, like the peer UART_RXD.
    initial forever begin
        @(negedge CLK);
        if (mon_en && UART_TXD === 1'b0) begin
            repeat (CPB / 2) @(negedge CLK);
            rx_ok = UART_TXD === 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge CLK);
                rx_d[i] = UART_TXD;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge CLK);
            rx_ok = rx_ok && (UART_TXD === ^rx_d);
`endif
            repeat (CPB) @(negedge CLK);
            rx_ok = rx_ok && (UART_TXD === 1'b1);
            checks++;
            if (!rx_ok) begin
                errors++;
                $display("FAIL rx_frame: byte %02h bad start/parity/stop, stop level %b required 1", rx_d, UART_TXD);
            end
            rx_q.push_back(rx_d);
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: BUSY=%b after %0d cycles, required 0", BUSY, budget);
        end
        repeat (2 * CPB) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        TX_VALID = 1'b1;
        TX_DATA = 8'($urandom);
        repeat (3) @(negedge CLK);
        checks += 4;
        if (UART_TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", UART_TXD); end
        if (TX_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", TX_READY); end
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", BUSY); end
        if (FIFO_COUNT !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", FIFO_COUNT); end
        RESET = 1'b0;
        TX_VALID = 1'b0;
        repeat (3 * CPB) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || UART_TXD !== 1'b1) begin
            errors++;
            $display("FAIL reset_push_ignored: BUSY=%b TXD=%b required 0/1", BUSY, UART_TXD);
        end
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        logic exp;
        rx_q.delete();
        TX_DATA = b;
        TX_VALID = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < FRAME + 6; k++) begin
            if (k == 0) TX_VALID = 1'b0;
            exp = (k < 2 || k >= 2 + FRAME) ? 1'b1 : frame_bit(b, (k - 2) / CPB);
            checks++;
            if (UART_TXD !== exp) begin
                errors++;
                $display("FAIL single_line: byte %02h cycle %0d got %b required %b", b, k, UART_TXD, exp);
            end
            if (k == 2 || k == FRAME + 2) begin
                checks++;
                if (BUSY !== (k == 2)) begin
                    errors++;
                    $display("FAIL single_busy: cycle %0d got %b required %b", k, BUSY, k == 2);
                end
            end
            @(negedge CLK);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            errors++;
            $display("FAIL single_rx: got %0d bytes first %02h required 1 byte %02h", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        logic exp;
        int idx;
        TX_DATA = b0;
        TX_VALID = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 2 * FRAME + 6; k++) begin
            if (k == 0) TX_DATA = b1;
            if (k == 1) TX_VALID = 1'b0;
            idx = (k - 2) / CPB;
            exp = (k < 2 || k >= 2 + 2 * FRAME) ? 1'b1 : frame_bit(idx < NB ? b0 : b1, idx % NB);
            checks++;
            if (UART_TXD !== exp) begin
                errors++;
                $display("FAIL b2b_line: cycle %0d got %b required %b", k, UART_TXD, exp);
            end
            if (k <= 2 || k == FRAME + 2) begin
                checks++;
                if (FIFO_COUNT !== (k <= 2 ? 4'd1 : 4'd0)) begin
                    errors++;
                    $display("FAIL b2b_count: cycle %0d got %0d required %0d", k, FIFO_COUNT, k <= 2 ? 1 : 0);
                end
            end
            if (k == 2 * FRAME + 2) begin
                checks++;
                if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b required 0", BUSY); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_fifo_full();
        int mcnt = 0;
        logic [7:0] acc[$];
        logic [7:0] d;
        rx_q.delete();
        for (int j = 0; j < 10; j++) begin
            d = 8'($urandom);
            TX_DATA = d;
            TX_VALID = 1'b1;
            checks++;
            if (TX_READY !== (mcnt < DEPTH)) begin
                errors++;
                $display("FAIL full_ready: push %0d got %b required %b", j, TX_READY, mcnt < DEPTH);
            end
            @(negedge CLK);
            if (mcnt < DEPTH) begin
                acc.push_back(d);
                mcnt++;
            end
            if (j == 1) mcnt--;
            checks++;
            if (FIFO_COUNT !== mcnt[3:0]) begin
                errors++;
                $display("FAIL full_count: push %0d got %0d required %0d", j, FIFO_COUNT, mcnt);
            end
        end
        TX_VALID = 1'b0;
        checks++;
        if (TX_READY !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b required 0", TX_READY); end
        wait_idle(10 * FRAME + 100);
        checks++;
        if (rx_q != acc) begin
            errors++;
            $display("FAIL full_rx: got %0d bytes required %0d", rx_q.size(), acc.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int n;
        for (int r = 0; r < 4; r++) begin
            rx_q.delete();
            exp_q.delete();
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom);
                TX_DATA = d;
                TX_VALID = 1'b1;
                checks++;
                if (TX_READY !== 1'b1) begin errors++; $display("FAIL rand_ready: round %0d got %b required 1", r, TX_READY); end
                exp_q.push_back(d);
                @(negedge CLK);
            end
            TX_VALID = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            wait_idle((n + 1) * FRAME + 50);
            checks++;
            if (rx_q != exp_q) begin
                errors++;
                $display("FAIL rand_rx: round %0d got %0d bytes required %0d", r, rx_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_loopback();
        rx_q.delete();
        TX_DATA = 8'h41;
        TX_VALID = 1'b1;
        @(negedge CLK);
        TX_VALID = 1'b0;
        wait_idle(FRAME + 50);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
            errors++;
            $display("FAIL loopback: got %0d bytes first %02h required 41", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows = 0;
        mon_en = 1'b0;
        for (int j = 0; j < 19; j++) begin
            TX_VALID = j < 4;
            TX_DATA = 8'($urandom);
            @(negedge CLK);
        end
        checks++;
        if (FIFO_COUNT !== 4'd3) begin errors++; $display("FAIL mid_queued: got %0d required 3", FIFO_COUNT); end
        RESET = 1'b1;
        TX_VALID = 1'b1;
        TX_DATA = 8'($urandom);
        @(negedge CLK);
        RESET = 1'b0;
        TX_VALID = 1'b0;
        checks += 4;
        if (UART_TXD !== 1'b1) begin errors++; $display("FAIL mid_txd: got %b required 1", UART_TXD); end
        if (FIFO_COUNT !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", FIFO_COUNT); end
        if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", BUSY); end
        if (TX_READY !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", TX_READY); end
        for (int k = 0; k < 5 * FRAME; k++) begin
            @(negedge CLK);
            if (UART_TXD !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_frames: %0d low cycles BUSY=%b required 0 and 0", lows, BUSY);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_frame(8'h55);
`ifdef UART_TX_PARITY_EN
        test_single_frame(8'h07);
        test_single_frame(8'h03);
`endif
        test_single_frame(8'($urandom));
        test_back_to_back(8'hA3, 8'h0F);
        test_fifo_full();
        test_random();
        test_loopback();
        test_reset_mid_frame();
        test_single_frame(8'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
